// File: rtl/mulu_pkg.sv
// rtl/mulu_pkg.sv - shared widths and pipeline constants for the unsigned array multiplier
package mulu_pkg;

   localparam int MULU_XW  = 2;
   localparam int MULU_YW  = 2;
   localparam int PW       = MULU_XW + MULU_YW;
   localparam int PIPE_LAT = 2;

endpackage

// File: rtl/mulu_fa.sv
// rtl/mulu_fa.sv - 1-bit full adder cell for the partial-product reduction array
module mulu_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mulu_x2y2_core.sv
// rtl/mulu_x2y2_core.sv - two-stage unsigned XWxYW array multiplier; MULU_READY_EN adds the rdy valid flag
module mulu_x2y2_core
   import mulu_pkg::*;
#(
   parameter int XW = MULU_XW,
   parameter int YW = MULU_YW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XW-1:0]    x,
   input  logic [YW-1:0]    y,
   output logic [XW+YW-1:0] p
`ifdef MULU_READY_EN
   ,
   output logic             rdy
`endif
);

   localparam int W = XW + YW;

   logic [XW-1:0]         x_q;
   logic [YW-1:0]         y_q;
   logic [YW-1:0][XW-1:0] pp;
   logic [YW-1:0][W-1:0]  acc;

   // Partial-product row i is x_q gated by bit i of y_q.
   for (genvar i = 0; i < YW; i++) begin : g_pp
      assign pp[i] = x_q & {XW{y_q[i]}};
   end

   // Row 0 seeds the accumulator; it occupies bits [XW-1:0] only.
   assign acc[0] = W'(pp[0]);

   // Each further row ripples pp[i] into acc bits [i+XW-1:i]; its carry-out
   // lands on bit i+XW and the bits below i pass through untouched.
   for (genvar i = 1; i < YW; i++) begin : g_row
      logic [XW:0]   c;
      logic [XW-1:0] s;

      assign c[0] = 1'b0;

      for (genvar j = 0; j < XW; j++) begin : g_col
         mulu_fa u_fa (
            .a    (acc[i-1][i+j]),
            .b    (pp[i][j]),
            .cin  (c[j]),
            .s    (s[j]),
            .cout (c[j+1])
         );
      end

      assign acc[i] = (W'({c[XW], s}) << i) | (acc[i-1] & ((W'(1) << i) - W'(1)));
   end

   // Operand capture followed by product capture; reset clears both stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
         p   <= '0;
      end else begin
         x_q <= x;
         y_q <= y;
         p   <= acc[YW-1];
      end
   end

`ifdef MULU_READY_EN
   logic [1:0] vld_q;

   // Valid token walks the two pipeline stages after reset release.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 2'b00;
      end else begin
         vld_q <= {vld_q[0], 1'b1};
      end
   end

   assign rdy = vld_q[1];
`endif

endmodule

// File: tb/tb_mulu_x2y2_core.sv
// tb/tb_mulu_x2y2_core.sv - self-checking bench for mulu_x2y2_core (optionally built with MULU_READY_EN)
module tb_mulu_x2y2_core;
   import mulu_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   x   = '0;
   logic [1:0]   y   = '0;
   logic [3:0]   p;
`ifdef MULU_READY_EN
   logic         rdy;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: operands and reset as seen at the previous edge.
   int prev_x    = 0;
   int prev_y    = 0;
   bit prev_rst  = 1'b1;
   int exp_p     = 0;
   bit have_exp  = 1'b0;

   mulu_x2y2_core #(.XW(MULU_XW), .YW(MULU_YW)) dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .y   (y),
      .p   (p)
`ifdef MULU_READY_EN
      ,
      .rdy (rdy)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one operand pair for one edge, then compare p against the rule:
   // p after an edge is the product of the operands taken at the previous
   // edge, or 0 if reset was high at either of those two edges.
   task automatic step(input int xi, input int yi, input bit r);
      x   = 2'(xi);
      y   = 2'(yi);
      rst = r;
      #2;
      if (have_exp) check("hold", int'(p), exp_p);
      @(posedge clk);
      #1;
      exp_p = (!r && !prev_rst) ? prev_x * prev_y : 0;
      check("p", int'(p), exp_p);
`ifdef MULU_READY_EN
      check("rdy", int'(rdy), (!r && !prev_rst) ? 1 : 0);
`endif
      have_exp = 1'b1;
      prev_x   = xi;
      prev_y   = yi;
      prev_rst = r;
   endtask

   initial begin
      // Reset held for 3 clocks with 3x3 presented, then release.
      for (int i = 0; i < 3; i++) step(3, 3, 1'b1);
      for (int i = 0; i < PIPE_LAT + 1; i++) step(3, 3, 1'b0);
      check("after_release_9", int'(p), 9);

      // Single operation then follow-on values.
      step(2, 3, 1'b0);
      step(1, 1, 1'b0);
      check("single_6", int'(p), 6);
      step(0, 2, 1'b0);
      step(0, 0, 1'b0);

      // Exhaustive sweep, one pair per clock.
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            step(a, b, 1'b0);

      // Back-to-back toggling between max and zero.
      for (int i = 0; i < 8; i++) step((i % 2) ? 0 : 3, (i % 2) ? 0 : 3, 1'b0);

      // Reset mid-stream with (2,2) flowing.
      for (int i = 0; i < 4; i++) step(2, 2, 1'b0);
      step(2, 2, 1'b1);
      check("midreset_0", int'(p), 0);
      for (int i = 0; i < PIPE_LAT; i++) step(2, 2, 1'b0);
      check("refill_4", int'(p), 4);
      step(2, 2, 1'b0);

      // Random operands with occasional reset pulses.
      for (int i = 0; i < 300; i++)
         step(int'($urandom_range(3)), int'($urandom_range(3)), ($urandom_range(19) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
